vending_ctrl: RTL
=================

Name: vending_ctrl

Overview:
- Transaction controller for the vending datapath.
- Holds per-product price and stock tables and accumulates inserted credit.
- Sequences each purchase: select, stock/credit check, dispense handshake, coin-by-coin change payout. Refunds use the same change path.
- Sits between the coin/keypad front end and the product and change dispenser actuators.

Parameters:
N_PROD, 3, number of products; product codes are 1..N_PROD and 0 means no selection
MW, 8, money width (prices, credit, coin values)
SW, 4, stock counter width per product

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  table write strobe (honoured only in IDLE)
cfg_idx  in  2  product code 1..N_PROD being configured
cfg_price  in  MW  price to store
cfg_stock  in  SW  stock count to store
coin_valid  in  1  coin inserted this cycle
coin_val  in  MW  value of inserted coin
sel  in  2  product select, 0 = none
re  in  1  refund request
vend_valid  out  1  dispense request to product actuator
vend_prod  out  2  product code being dispensed
vend_ready  in  1  actuator accepts dispense
chg_valid  out  1  change coin request
chg_coin  out  MW  coin value requested: 10, 5 or 1
chg_ready  in  1  change dispenser accepts coin
credit  out  MW  current credit, or remaining change while in CHANGE
busy  out  1  high in VEND and CHANGE
err  out  2  one-cycle pulse: 0 none, 1 insufficient credit, 2 sold out, 3 rejected coin

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; credit, change remainder, vend_valid, vend_prod, chg_valid, chg_coin, err, busy all 0.
  - Price and stock tables cleared to 0.
- Reset asserted mid-VEND or mid-CHANGE aborts the transaction. Credit is lost; no request remains asserted the following cycle.
- IDLE, evaluated at each posedge in this priority order:
  1. cfg_we with cfg_idx in 1..N_PROD writes price and stock. The write is visible from the next cycle. cfg_idx = 0 is ignored.
  2. Effective credit E = credit + coin_val when coin_valid, else credit. If the sum exceeds 2^MW-1, the coin is not added, err = 3, and E = credit.
  3. re = 1: remainder <= E, credit <= 0.
     - If E > 0, go to CHANGE.
     - If E = 0, stay in IDLE with no error.
     - re overrides sel.
  4. sel = p != 0, price P = price[p]:
     - stock[p] = 0: err = 2, credit <= E, stay in IDLE.
     - Else if E < P: err = 1, credit <= E, stay in IDLE.
     - Else: vend_prod <= p, vend_valid <= 1, remainder <= E - P, credit <= 0, go to VEND. Latency is exactly one cycle from the sel sample to vend_valid.
     - A price equal to credit is allowed.
  5. Otherwise credit <= E.
- A coin and a select in the same cycle are combined, so the coin counts toward the purchase.
- A cfg write and a select in the same cycle: the select uses the old table.
- A select with out-of-range p > N_PROD is ignored with no error.
- VEND:
  - vend_valid is held with vend_prod stable until a cycle with vend_ready = 1.
  - On that cycle: stock[p] decrements, vend_valid drops the next cycle, and the FSM goes to CHANGE if remainder > 0, else to IDLE.
- CHANGE:
  - chg_valid = 1 and chg_coin = greedy choice: 10 if remainder >= 10, else 5 if >= 5, else 1.
  - chg_coin is stable while chg_ready = 0.
  - On a chg_ready cycle, remainder -= chg_coin. When it reaches 0, go to IDLE with chg_valid low the next cycle.
- In VEND and CHANGE, coin_valid produces err = 3 and the coin is not credited. sel, re and cfg_we are ignored.
- err is registered, high for exactly one cycle, and 0 otherwise.
- Width rules:
  - All money arithmetic is MW-bit unsigned.
  - Overflow is detected using an MW+1-bit sum.
  - Stock never decrements below 0; VEND is only entered when stock > 0.

Decomposition:
- Package vending_pkg holds:
  - state enum {IDLE, VEND, CHANGE}
  - err code constants ERR_NONE, ERR_INSUF, ERR_SOLDOUT, ERR_COIN
  - denomination constants COIN_10, COIN_5, COIN_1
- One sub-module, vending_change_unit: loadable remainder register, greedy coin selection, chg_valid/chg_ready handshake, done flag.
- Tables, credit and FSM stay in vending_ctrl.

Test Plan:
- Config prices {15, 30, 7} and stock {2, 1, 0}; insert coins 10, 10; sel=1 -> vend_valid=1, vend_prod=1 one cycle later. With vend_ready after 3 cycles, then chg_ready tied 1 -> chg_coin 5 for one cycle, then IDLE with credit=0 and stock[1]=1.
- Credit 20, sel=2 (price 30) -> err=1 for one cycle, credit stays 20. Then sel=3 (stock 0) -> err=2, credit stays 20.
- Credit 20, re=1 with sel=1 in the same cycle -> no vend; change sequence 10, 10; credit=0.
- Credit 250, coin 10 -> err=3, credit stays 250. Coin inserted during VEND -> err=3, not credited.
- Credit 10, coin 5 plus sel=1 (price 15) in the same cycle -> vend succeeds with remainder 0, VEND goes straight to IDLE with no chg_valid.
- Credit 28, sel=1 -> change 10, 1, 1, 1 with chg_ready stalled 2 cycles on the first coin (chg_coin holds 10). rst asserted on the second coin -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types, codes and helpers for the vending transaction controller.
package vending_pkg;

    localparam int unsigned N_PROD = 3;   // product codes 1..N_PROD, 0 = none
    localparam int unsigned MW     = 8;   // money width
    localparam int unsigned SW     = 4;   // stock counter width
    localparam int unsigned PW     = 2;   // product code width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INSUF   = 2'd1;
    localparam logic [1:0] ERR_SOLDOUT = 2'd2;
    localparam logic [1:0] ERR_COIN    = 2'd3;

    localparam logic [MW-1:0] COIN_10 = MW'(10);
    localparam logic [MW-1:0] COIN_5  = MW'(5);
    localparam logic [MW-1:0] COIN_1  = MW'(1);

    // One product table entry as written by the configuration port.
    typedef struct packed {
        logic [MW-1:0] price;
        logic [SW-1:0] stock;
    } prod_entry_t;

    // Largest denomination not exceeding the remainder (1 for any nonzero rest).
    function automatic logic [MW-1:0] greedy_coin(input logic [MW-1:0] rem);
        logic [MW-1:0] coin;
        coin = COIN_1;
        if (rem >= COIN_10) begin
            coin = COIN_10;
        end else if (rem >= COIN_5) begin
            coin = COIN_5;
        end
        return coin;
    endfunction

    // True for a real product code 1..N_PROD.
    function automatic logic prod_in_range(input logic [PW-1:0] p);
        logic ok;
        ok = 1'b0;
        for (int unsigned i = 1; i <= N_PROD; i++) begin
            if (p == PW'(i)) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/vending_change_unit.sv
// Change payout engine: holds the remainder and pays it out one greedy coin
// at a time over a valid/ready handshake.
// Ports: load_en/load_val  load the remainder register
//        start             begin payout from the (newly loaded) remainder
//        chg_valid/chg_coin/chg_ready  coin request handshake
//        rem               registered remainder
//        rem_next_c        remainder value for the next cycle
//        done_c            last coin accepted this cycle
module vending_change_unit
    import vending_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [MW-1:0] load_val,
    input  logic          start,
    input  logic          chg_ready,
    output logic          chg_valid,
    output logic [MW-1:0] chg_coin,
    output logic [MW-1:0] rem,
    output logic [MW-1:0] rem_next_c,
    output logic          done_c
);

    logic [MW-1:0] rem_q, rem_d;
    logic          chg_valid_q, chg_valid_d;
    logic [MW-1:0] chg_coin_q, chg_coin_d;
    logic [MW-1:0] rem_after;

    // Next remainder and coin selection; coin only changes on acceptance.
    always_comb begin
        rem_d       = rem_q;
        chg_valid_d = chg_valid_q;
        chg_coin_d  = chg_coin_q;
        rem_after   = rem_q - chg_coin_q;
        done_c      = chg_valid_q && chg_ready && (rem_after == '0);

        if (load_en) begin
            rem_d = load_val;
        end

        if (start) begin
            chg_valid_d = 1'b1;
            chg_coin_d  = greedy_coin(rem_d);
        end else if (chg_valid_q && chg_ready) begin
            rem_d = rem_after;
            if (rem_after == '0) begin
                chg_valid_d = 1'b0;
                chg_coin_d  = '0;
            end else begin
                chg_coin_d  = greedy_coin(rem_after);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            chg_valid_q <= 1'b0;
            chg_coin_q  <= '0;
        end else begin
            rem_q       <= rem_d;
            chg_valid_q <= chg_valid_d;
            chg_coin_q  <= chg_coin_d;
        end
    end

    assign chg_valid  = chg_valid_q;
    assign chg_coin   = chg_coin_q;
    assign rem        = rem_q;
    assign rem_next_c = rem_d;

endmodule

// File: rtl/vending_ctrl.sv
// Vending transaction controller: price/stock tables, credit accumulation,
// purchase sequencing and refund/change payout.
// Ports: cfg_*      table write port (IDLE only)
//        coin_*     coin insertion
//        sel, re    product select and refund request
//        vend_*     dispense handshake to product actuator
//        chg_*      change coin handshake
//        credit     credit, or remaining change while paying out
//        busy, err  status; err is a one-cycle code pulse
module vending_ctrl
    import vending_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_idx,
    input  logic [MW-1:0] cfg_price,
    input  logic [SW-1:0] cfg_stock,
    input  logic          coin_valid,
    input  logic [MW-1:0] coin_val,
    input  logic [1:0]    sel,
    input  logic          re,
    output logic          vend_valid,
    output logic [1:0]    vend_prod,
    input  logic          vend_ready,
    output logic          chg_valid,
    output logic [MW-1:0] chg_coin,
    input  logic          chg_ready,
    output logic [MW-1:0] credit,
    output logic          busy,
    output logic [1:0]    err
);

    state_e        state_q, state_d;
    logic [MW-1:0] credit_q, credit_d;
    logic          vend_valid_q, vend_valid_d;
    logic [1:0]    vend_prod_q, vend_prod_d;
    logic          busy_q, busy_d;
    logic [1:0]    err_q, err_d;
    prod_entry_t   tbl_q [0:N_PROD];
    prod_entry_t   tbl_d [0:N_PROD];

    logic          ld_en;
    logic [MW-1:0] ld_val;
    logic          chg_start;
    logic [MW-1:0] rem;
    logic [MW-1:0] rem_next_c;
    logic          done_c;

    logic [MW:0]   coin_sum;
    logic [MW-1:0] eff_credit;
    prod_entry_t   sel_entry;

    vending_change_unit u_change (
        .clk        (clk),
        .rst        (rst),
        .load_en    (ld_en),
        .load_val   (ld_val),
        .start      (chg_start),
        .chg_ready  (chg_ready),
        .chg_valid  (chg_valid),
        .chg_coin   (chg_coin),
        .rem        (rem),
        .rem_next_c (rem_next_c),
        .done_c     (done_c)
    );

    // Next-state, table update and output computation.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        vend_valid_d = vend_valid_q;
        vend_prod_d  = vend_prod_q;
        err_d        = ERR_NONE;
        tbl_d        = tbl_q;
        ld_en        = 1'b0;
        ld_val       = '0;
        chg_start    = 1'b0;

        // Overflow is caught in the carry bit of the widened sum.
        coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
        eff_credit = credit_q;
        // Select reads the table before any same-cycle cfg write lands.
        sel_entry  = tbl_q[sel];

        unique case (state_q)
            IDLE: begin
                if (cfg_we && prod_in_range(cfg_idx)) begin
                    tbl_d[cfg_idx] = '{price: cfg_price, stock: cfg_stock};
                end

                if (coin_valid) begin
                    if (coin_sum[MW]) begin
                        err_d = ERR_COIN;
                    end else begin
                        eff_credit = coin_sum[MW-1:0];
                    end
                end

                if (re) begin
                    credit_d = '0;
                    ld_en    = 1'b1;
                    ld_val   = eff_credit;
                    if (eff_credit != '0) begin
                        chg_start = 1'b1;
                        state_d   = CHANGE;
                    end
                end else if (prod_in_range(sel)) begin
                    if (sel_entry.stock == '0) begin
                        err_d    = ERR_SOLDOUT;
                        credit_d = eff_credit;
                    end else if (eff_credit < sel_entry.price) begin
                        err_d    = ERR_INSUF;
                        credit_d = eff_credit;
                    end else begin
                        vend_valid_d = 1'b1;
                        vend_prod_d  = sel;
                        ld_en        = 1'b1;
                        ld_val       = eff_credit - sel_entry.price;
                        credit_d     = '0;
                        state_d      = VEND;
                    end
                end else begin
                    credit_d = eff_credit;
                end
            end

            VEND: begin
                if (coin_valid) begin
                    err_d = ERR_COIN;
                end
                if (vend_ready) begin
                    if (tbl_q[vend_prod_q].stock != '0) begin
                        tbl_d[vend_prod_q].stock = tbl_q[vend_prod_q].stock - SW'(1);
                    end
                    vend_valid_d = 1'b0;
                    vend_prod_d  = '0;
                    if (rem != '0) begin
                        chg_start = 1'b1;
                        state_d   = CHANGE;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end

            CHANGE: begin
                if (coin_valid) begin
                    err_d = ERR_COIN;
                end
                if (done_c) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While paying out, the credit output shows the remaining change.
        if (state_d == CHANGE) begin
            credit_d = rem_next_c;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            vend_valid_q <= 1'b0;
            vend_prod_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= ERR_NONE;
            tbl_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            vend_valid_q <= vend_valid_d;
            vend_prod_q  <= vend_prod_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            tbl_q        <= tbl_d;
        end
    end

    assign credit     = credit_q;
    assign vend_valid = vend_valid_q;
    assign vend_prod  = vend_prod_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
